frame_uart_streamer: RTL and testbench

Parametrised frame-readout controller between `line_buffer` and `uart_send`/`uart_receive`; replaces the hard-wired 8-bit readout loop in the top level. It decodes single-byte UART commands, walks the line buffer line by line with optional row/column decimation, and emits each pixel as one truncated byte or two full-width bytes. It also handles a clean abort and a frame-done indication.

---
 rtl/frame_uart_streamer_pkg.sv | 25 ++
 rtl/frame_uart_streamer_if.sv | 38 +++
 rtl/frame_uart_streamer_rx_cmd_decoder.sv | 41 ++++
 rtl/frame_uart_streamer.sv | 209 ++++++++++++++++++++
 tb/tb_frame_uart_streamer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_uart_streamer_pkg.sv
// Shared constants and FSM state type for the frame UART streamer.
// FRAME_UART_STREAMER_LINE_HEADER_EN adds the HDR0/HDR1 states.
package cam_pkg;

  localparam logic [7:0] CMD_START_NARROW = 8'h53;
  localparam logic [7:0] CMD_START_WIDE   = 8'h57;
  localparam logic [7:0] CMD_ABORT        = 8'h58;
  localparam logic [7:0] LINE_SYNC        = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_LINE,
    FETCH,
    SEND_HI,
    SEND_LO,
    WAIT_TX,
    NEXT
`ifdef FRAME_UART_STREAMER_LINE_HEADER_EN
    ,
    HDR0,
    HDR1
`endif
  } state_e;

endpackage

// File: rtl/frame_uart_streamer_if.sv
// Buffer, UART and status signals of the frame UART streamer.
// master = streamer side, slave = buffer/UART side.
interface frame_uart_streamer_if #(
  parameter int H     = 752,
  parameter int V     = 480,
  parameter int PIX_W = 10
);
  localparam int CW = $clog2(H);
  localparam int LW = $clog2(V);

  logic [7:0]       RX_DATA;
  logic             RX_READY;
  logic             LINE_READY;
  logic [PIX_W-1:0] BUF_DATA;
  logic [LW-1:0]    LINE_SEL;
  logic [CW-1:0]    COL_SEL;
  logic             RESET_READY_FLAG;
  logic [7:0]       TX_DATA;
  logic             TX_VALID;
  logic             TX_IDLE;
  logic             BUSY;
  logic             FRAME_DONE;

  modport master (
    input  RX_DATA, RX_READY, LINE_READY,
    input  BUF_DATA, TX_IDLE,
    output LINE_SEL, COL_SEL, RESET_READY_FLAG,
    output TX_DATA, TX_VALID, BUSY, FRAME_DONE
  );

  modport slave (
    output RX_DATA, RX_READY, LINE_READY,
    output BUF_DATA, TX_IDLE,
    input  LINE_SEL, COL_SEL, RESET_READY_FLAG,
    input  TX_DATA, TX_VALID, BUSY, FRAME_DONE
  );

endinterface

// File: rtl/frame_uart_streamer_rx_cmd_decoder.sv
// RX_READY rising-edge detect and single-byte command decode.
// Emits registered one-cycle start/abort pulses.
import cam_pkg::*;

module rx_cmd_decoder (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_ready_i,
  output logic       start_narrow_o,
  output logic       start_wide_o,
  output logic       abort_o
);

  logic rdy_q;
  logic sn_q;
  logic sw_q;
  logic ab_q;
  logic rise;

  assign rise = rx_ready_i & ~rdy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdy_q <= 1'b0;
      sn_q  <= 1'b0;
      sw_q  <= 1'b0;
      ab_q  <= 1'b0;
    end else begin
      rdy_q <= rx_ready_i;
      sn_q  <= rise && (rx_data_i == CMD_START_NARROW);
      sw_q  <= rise && (rx_data_i == CMD_START_WIDE);
      ab_q  <= rise && (rx_data_i == CMD_ABORT);
    end
  end

  assign start_narrow_o = sn_q;
  assign start_wide_o   = sw_q;
  assign abort_o        = ab_q;

endmodule

// File: rtl/frame_uart_streamer.sv
// Line-buffer to UART frame readout with decimation and wide mode.
// FRAME_UART_STREAMER_LINE_HEADER_EN: 0xA5 + line index per line.
import cam_pkg::*;

module frame_uart_streamer #(
  parameter int H        = 752,
  parameter int V        = 480,
  parameter int PIX_W    = 10,
  parameter int COL_STEP = 1,
  parameter int ROW_STEP = 1
) (
  input logic                  CLK,
  input logic                  RST,
  frame_uart_streamer_if.master bus
);

  localparam int CW = $clog2(H);
  localparam int LW = $clog2(V);

  localparam logic [CW:0] COL_INC = (CW+1)'(COL_STEP);
  localparam logic [CW:0] COL_LIM = (CW+1)'(H);
  localparam logic [LW:0] ROW_INC = (LW+1)'(ROW_STEP);
  localparam logic [LW:0] ROW_LIM = (LW+1)'(V);

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic          wide_q, wide_d;
  logic [LW-1:0] line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          rrf_q, rrf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic start_n;
  logic start_w;
  logic abort;

  rx_cmd_decoder u_dec (
    .clk_i          (CLK),
    .rst_i          (RST),
    .rx_data_i      (bus.RX_DATA),
    .rx_ready_i     (bus.RX_READY),
    .start_narrow_o (start_n),
    .start_wide_o   (start_w),
    .abort_o        (abort)
  );

  logic [7:0] narrow_b;
  logic [7:0] hi_b;
  logic [7:0] lo_b;

  assign narrow_b = bus.BUF_DATA[PIX_W-1 -: 8];
  assign hi_b     = 8'(bus.BUF_DATA >> 8);
  assign lo_b     = bus.BUF_DATA[7:0];

  logic [CW:0] col_nxt;
  logic [LW:0] line_nxt;
  logic        col_wrap;
  logic        line_wrap;

  assign col_nxt   = {1'b0, col_q} + COL_INC;
  assign line_nxt  = {1'b0, line_q} + ROW_INC;
  assign col_wrap  = col_nxt >= COL_LIM;
  assign line_wrap = line_nxt >= ROW_LIM;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    wide_d     = wide_q;
    line_d     = line_q;
    col_d      = col_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    rrf_d      = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_n || start_w) begin
          state_d = WAIT_LINE;
          wide_d  = start_w;
        end
      end
      WAIT_LINE: begin
        // skip the cycle the clear pulse is out: the flag may be stale
        if (bus.LINE_READY && !rrf_q) begin
`ifdef FRAME_UART_STREAMER_LINE_HEADER_EN
          state_d = HDR0;
`else
          state_d = FETCH;
`endif
        end
      end
`ifdef FRAME_UART_STREAMER_LINE_HEADER_EN
      HDR0: begin
        if (bus.TX_IDLE) begin
          tx_valid_d = 1'b1;
          tx_data_d  = LINE_SYNC;
          ret_d      = HDR1;
          state_d    = WAIT_TX;
        end
      end
      HDR1: begin
        if (bus.TX_IDLE) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'(line_q);
          ret_d      = FETCH;
          state_d    = WAIT_TX;
        end
      end
`endif
      FETCH: begin
        state_d = SEND_HI;
      end
      SEND_HI: begin
        if (bus.TX_IDLE) begin
          tx_valid_d = 1'b1;
          tx_data_d  = wide_q ? hi_b : narrow_b;
          ret_d      = wide_q ? SEND_LO : NEXT;
          state_d    = WAIT_TX;
        end
      end
      SEND_LO: begin
        if (bus.TX_IDLE) begin
          tx_valid_d = 1'b1;
          tx_data_d  = lo_b;
          ret_d      = NEXT;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // TX_IDLE lags the strobe by one cycle
        if (!tx_valid_q && bus.TX_IDLE) begin
          state_d = ret_q;
        end
      end
      NEXT: begin
        if (!col_wrap) begin
          col_d   = col_nxt[CW-1:0];
          state_d = FETCH;
        end else begin
          col_d = '0;
          if (!line_wrap) begin
            line_d  = line_nxt[LW-1:0];
            rrf_d   = 1'b1;
            state_d = WAIT_LINE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
    end

    if (state_d == IDLE) begin
      line_d = '0;
      col_d  = '0;
      rrf_d  = 1'b1;
    end

    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      wide_q     <= 1'b0;
      line_q     <= '0;
      col_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rrf_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wide_q     <= wide_d;
      line_q     <= line_d;
      col_q      <= col_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rrf_q      <= rrf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.LINE_SEL         = line_q;
  assign bus.COL_SEL          = col_q;
  assign bus.RESET_READY_FLAG = rrf_q;
  assign bus.TX_DATA          = tx_data_q;
  assign bus.TX_VALID         = tx_valid_q;
  assign bus.BUSY             = busy_q;
  assign bus.FRAME_DONE       = done_q;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Bench for frame_uart_streamer: full-rate and 3/2-decimated instances,
// with line buffer and uart_send models.
module tb_frame_uart_streamer;

`ifdef FRAME_UART_STREAMER_LINE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_uart_streamer_if #(.H(8), .V(4), .PIX_W(10)) b0 ();
  frame_uart_streamer_if #(.H(8), .V(4), .PIX_W(10)) b1 ();

  frame_uart_streamer #(
    .H(8), .V(4), .PIX_W(10), .COL_STEP(1), .ROW_STEP(1)
  ) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (b0)
  );

  frame_uart_streamer #(
    .H(8), .V(4), .PIX_W(10), .COL_STEP(3), .ROW_STEP(2)
  ) u_dec (
    .CLK (clk),
    .RST (rst),
    .bus (b1)
  );

  logic [7:0] rxd0 = 8'h00, rxd1 = 8'h00;
  logic       rxr0 = 1'b0, rxr1 = 1'b0;
  logic       lr0 = 1'b1;
  int         pat0 = 0;
  int         wt0 = 0;
  int         cnt0 = 0, cnt1 = 0;
  logic       clr = 1'b0;

  assign b0.RX_DATA    = rxd0;
  assign b0.RX_READY   = rxr0;
  assign b0.LINE_READY = lr0;
  assign b0.TX_IDLE    = (cnt0 == 0);
  assign b1.RX_DATA    = rxd1;
  assign b1.RX_READY   = rxr1;
  assign b1.LINE_READY = 1'b1;
  assign b1.TX_IDLE    = (cnt1 == 0);

  function automatic int pixv(input int pat, input int l, input int c);
    case (pat)
      0:       return 'h3FC;
      1:       return 'h2A5;
      default: return (l * 8 + c) * 4;
    endcase
  endfunction

  always @(posedge clk) begin
    b0.BUF_DATA <= 10'(pixv(pat0, int'(b0.LINE_SEL), int'(b0.COL_SEL)));
    b1.BUF_DATA <= 10'(pixv(2, int'(b1.LINE_SEL), int'(b1.COL_SEL)));
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt0 <= 0;
      cnt1 <= 0;
    end else begin
      if (b0.TX_VALID) cnt0 <= wt0;
      else if (cnt0 > 0) cnt0 <= cnt0 - 1;
      if (b1.TX_VALID) cnt1 <= 0;
      else if (cnt1 > 0) cnt1 <= cnt1 - 1;
    end
  end

  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic [7:0] exp_q[$];
  int rrfc0 = 0, donec0 = 0, viol0 = 0;
  int rrfc1 = 0, donec1 = 0;

  always @(posedge clk) begin
    if (clr) begin
      got0.delete();
      got1.delete();
      rrfc0 <= 0; donec0 <= 0; viol0 <= 0;
      rrfc1 <= 0; donec1 <= 0;
    end else begin
      if (b0.TX_VALID) got0.push_back(b0.TX_DATA);
      if (b0.TX_VALID && !b0.TX_IDLE) viol0 <= viol0 + 1;
      if (b0.RESET_READY_FLAG && b0.BUSY && !b0.FRAME_DONE)
        rrfc0 <= rrfc0 + 1;
      if (b0.FRAME_DONE) donec0 <= donec0 + 1;
      if (b1.TX_VALID) got1.push_back(b1.TX_DATA);
      if (b1.RESET_READY_FLAG && b1.BUSY && !b1.FRAME_DONE)
        rrfc1 <= rrfc1 + 1;
      if (b1.FRAME_DONE) donec1 <= donec1 + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic send_cmd(input int w, input logic [7:0] c);
    @(negedge clk);
    if (w == 0) begin rxd0 = c; rxr0 = 1'b1; end
    else begin rxd1 = c; rxr1 = 1'b1; end
    repeat (2) @(negedge clk);
    rxr0 = 1'b0;
    rxr1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int w, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (w == 0 && donec0 != 0) break;
      if (w == 1 && donec1 != 0) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (got0.size() >= n) break;
      @(negedge clk);
    end
    if (got0.size() < n) chk("wait_bytes_timeout", got0.size(), n);
  endtask

  task automatic build_exp(input int wide, input int pat,
                           input int cs, input int rs);
    exp_q.delete();
    for (int l = 0; l < 4; l += rs) begin
`ifdef FRAME_UART_STREAMER_LINE_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(l));
`endif
      for (int c = 0; c < 8; c += cs) begin
        int p;
        p = pixv(pat, l, c);
        if (wide != 0) begin
          exp_q.push_back(8'(p >> 8));
          exp_q.push_back(8'(p));
        end else begin
          exp_q.push_back(8'(p >> 2));
        end
      end
    end
  endtask

  task automatic check_stream(input string nm, input int w);
    logic [7:0] g[$];
    int m;
    if (w == 0) g = got0;
    else g = got1;
    m = 0;
    for (int i = 0; i < g.size() && i < exp_q.size(); i++)
      if (g[i] == exp_q[i]) m++;
    chk({nm, "_len"}, g.size(), exp_q.size());
    chk({nm, "_match"}, m, exp_q.size());
  endtask

  typedef struct {
    logic [7:0] cmd;
    int pat;
    int wt;
    int nb;
    int nrrf;
    int ndone;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h53, 0, 0, 32, 3, 1};
    tbl[1] = '{8'h57, 1, 0, 64, 3, 1};
    tbl[2] = '{8'h53, 2, 0, 32, 3, 1};
    tbl[3] = '{8'h57, 2, 3, 64, 3, 1};
    tbl[4] = '{8'h41, 2, 0, 0, 0, 0};
    tbl[5] = '{8'h58, 2, 0, 0, 0, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", b0.TX_VALID, 0);
    chk("rst_tx_data", b0.TX_DATA, 0);
    chk("rst_line_sel", b0.LINE_SEL, 0);
    chk("rst_col_sel", b0.COL_SEL, 0);
    chk("rst_rrf", b0.RESET_READY_FLAG, 1);
    chk("rst_busy", b0.BUSY, 0);
    chk("rst_done", b0.FRAME_DONE, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      int is_w;
      int exp_len;
      string tag;
      tag = $sformatf("vec%0d", i);
      clear_mon();
      pat0 = tbl[i].pat;
      wt0  = tbl[i].wt;
      send_cmd(0, tbl[i].cmd);
      if (tbl[i].nb > 0) wait_done(0, 20000);
      else repeat (60) @(negedge clk);
      repeat (3) @(negedge clk);
      is_w = (tbl[i].cmd == 8'h57) ? 1 : 0;
      if (tbl[i].nb > 0) build_exp(is_w, tbl[i].pat, 1, 1);
      else exp_q.delete();
      exp_len = tbl[i].nb + ((tbl[i].nb > 0) ? HDR * 8 : 0);
      chk({tag, "_count"}, got0.size(), exp_len);
      check_stream(tag, 0);
      chk({tag, "_rrf"}, rrfc0, tbl[i].nrrf);
      chk({tag, "_done"}, donec0, tbl[i].ndone);
      chk({tag, "_viol"}, viol0, 0);
      chk({tag, "_busy"}, b0.BUSY, 0);
    end

    // latency checks, then abort after 10 bytes
    clear_mon();
    pat0 = 2;
    wt0  = 0;
    lr0  = 1'b0;
    @(negedge clk);
    rxd0 = 8'h53;
    rxr0 = 1'b1;
    @(negedge clk);
    chk("busy_lat_c1", b0.BUSY, 0);
    @(negedge clk);
    chk("busy_lat_c2", b0.BUSY, 1);
    rxr0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_line_hold", got0.size(), 0);
    chk("wait_line_rrf", b0.RESET_READY_FLAG, 0);
    lr0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("tx_lat_c%0d", k), b0.TX_VALID,
          (k == 3 - HDR) ? 1 : 0);
    end
    wait_bytes(10, 2000);
    begin
      int n;
      @(negedge clk);
      rxd0 = 8'h58;
      rxr0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy", b0.BUSY, 0);
      chk("abort_rrf", b0.RESET_READY_FLAG, 1);
      n = got0.size();
      rxr0 = 1'b0;
      repeat (100) @(negedge clk);
      chk("abort_no_tx", got0.size(), n);
      chk("abort_no_done", donec0, 0);
    end
    clear_mon();
    send_cmd(0, 8'h53);
    wait_done(0, 20000);
    repeat (3) @(negedge clk);
    build_exp(0, 2, 1, 1);
    check_stream("restart", 0);
    chk("restart_done", donec0, 1);

    // slow uart_send plus a second 'S' mid-frame
    clear_mon();
    wt0 = 50;
    send_cmd(0, 8'h53);
    wait_bytes(5, 2000);
    send_cmd(0, 8'h53);
    wait_done(0, 20000);
    repeat (3) @(negedge clk);
    build_exp(0, 2, 1, 1);
    check_stream("slow", 0);
    chk("slow_done", donec0, 1);
    chk("slow_viol", viol0, 0);
    repeat (60) @(negedge clk);
    chk("slow_no_restart", b0.BUSY, 0);
    wt0 = 0;

    // decimated instance: columns 0,3,6 on lines 0,2
    clear_mon();
    send_cmd(1, 8'h53);
    wait_done(1, 5000);
    chk("dec_bytes_at_done", got1.size(), 6 + HDR * 4);
    repeat (3) @(negedge clk);
    build_exp(0, 2, 3, 2);
    check_stream("dec", 1);
    chk("dec_rrf", rrfc1, 1);
    chk("dec_done", donec1, 1);
    chk("dec_busy", b1.BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
